// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: decode-stage immediate generator.
// Decodes the immediate for the selected format, sign/zero-extends it to XLEN,
// and registers it behind a valid/ready handshake. A two-entry buffer
// (OUT + SKID) lets in_ready come straight from a register while still never
// dropping or duplicating a result under downstream backpressure.
module imm_extend_pipe #(
    parameter int XLEN  = 32,   // 32 or 64
    parameter int TAG_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:7]       in_instr,
    input  logic [2:0]        in_immsrc,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_immext,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_err
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,   // OUT and SKID invalid
        ONE   = 2'd1,   // OUT valid
        FULL  = 2'd2    // OUT and SKID valid
    } state_t;

    state_t state_q, state_nxt;

    logic [XLEN-1:0]  out_imm_q,  skid_imm_q;
    logic [TAG_W-1:0] out_tag_q,  skid_tag_q;
    logic             out_err_q,  skid_err_q;

    logic [31:0]      imm32;
    logic             sext;
    logic [XLEN-1:0]  dec_imm;
    logic             dec_err;

    logic             accept, drain;
    logic             load_out_new, load_out_skid, load_skid;

    // Only SKID occupancy blocks the input, so in_ready is a pure register decode.
    assign in_ready   = (state_q != FULL);
    assign out_valid  = (state_q != EMPTY);
    assign out_immext = out_imm_q;
    assign out_tag    = out_tag_q;
    assign out_err    = out_err_q;

    assign accept = in_valid && in_ready;
    assign drain  = out_valid && out_ready;

    // Immediate decode: build a 32-bit pattern, then widen by sign or zero.
    always_comb begin
        imm32   = 32'd0;
        sext    = 1'b1;
        dec_err = 1'b0;
        case (in_immsrc)
            3'b000: imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
            3'b001: imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            3'b010: imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                             in_instr[30:25], in_instr[11:8], 1'b0};
            3'b011: imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                             in_instr[20], in_instr[30:21], 1'b0};
            3'b100: imm32 = {in_instr[31:12], 12'b0};
            3'b101: begin
                sext = 1'b0;
                if (XLEN == 64) begin
                    imm32 = {26'b0, in_instr[25:20]};
                end else begin
                    // RV32 shifts only have 5 bits; bit 25 set is an encoding error
                    imm32   = {27'b0, in_instr[24:20]};
                    dec_err = in_instr[25];
                end
            end
            3'b110: begin
                sext  = 1'b0;
                imm32 = {27'b0, in_instr[19:15]};
            end
            default: begin
                sext    = 1'b0;
                imm32   = 32'd0;
                dec_err = 1'b1;
            end
        endcase
        dec_imm = sext ? XLEN'($signed(imm32)) : XLEN'(imm32);
    end

    // Buffer FSM: next state and which register loads from where.
    always_comb begin
        state_nxt     = state_q;
        load_out_new  = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_nxt    = ONE;
                    load_out_new = 1'b1;
                end
            end
            ONE: begin
                if (accept && drain) begin
                    load_out_new = 1'b1;
                end else if (accept) begin
                    state_nxt = FULL;
                    load_skid = 1'b1;
                end else if (drain) begin
                    state_nxt = EMPTY;
                end
            end
            FULL: begin
                if (drain) begin
                    state_nxt     = ONE;
                    load_out_skid = 1'b1;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= EMPTY;
        else       state_q <= state_nxt;
    end

    // OUT and SKID payload registers; cleared on reset so outputs read zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_imm_q  <= '0;
            out_tag_q  <= '0;
            out_err_q  <= 1'b0;
            skid_imm_q <= '0;
            skid_tag_q <= '0;
            skid_err_q <= 1'b0;
        end else begin
            if (load_out_new) begin
                out_imm_q <= dec_imm;
                out_tag_q <= in_tag;
                out_err_q <= dec_err;
            end else if (load_out_skid) begin
                out_imm_q <= skid_imm_q;
                out_tag_q <= skid_tag_q;
                out_err_q <= skid_err_q;
            end
            if (load_skid) begin
                skid_imm_q <= dec_imm;
                skid_tag_q <= in_tag;
                skid_err_q <= dec_err;
            end
        end
    end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Bench for imm_extend_pipe: an XLEN=32 and an XLEN=64 instance share all
// inputs, so one stimulus stream checks both widths.
module tb_imm_extend_pipe;

    logic        clk = 1'b0;
    logic        reset, in_valid, out_ready;
    logic [31:0] instr;
    logic [2:0]  sel;
    logic [4:0]  tag;

    logic        rdy_a, vld_a, err_a, rdy_b, vld_b, err_b;
    logic [31:0] imm_a;
    logic [63:0] imm_b;
    logic [4:0]  tag_a, tag_b;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [31:0] a;
        logic [63:0] b;
        logic        ea, eb;
        logic [4:0]  t;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    imm_extend_pipe #(.XLEN(32), .TAG_W(5)) dut_a (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_a),
        .in_instr(instr[31:7]), .in_immsrc(sel), .in_tag(tag),
        .out_valid(vld_a), .out_ready(out_ready), .out_immext(imm_a),
        .out_tag(tag_a), .out_err(err_a)
    );

    imm_extend_pipe #(.XLEN(64), .TAG_W(5)) dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_b),
        .in_instr(instr[31:7]), .in_immsrc(sel), .in_tag(tag),
        .out_valid(vld_b), .out_ready(out_ready), .out_immext(imm_b),
        .out_tag(tag_b), .out_err(err_b)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] w, input logic [2:0] s, input logic [4:0] t);
        in_valid = v;
        instr    = w;
        sel      = s;
        tag      = t;
    endtask

    // Reference decode used only by the random stress phase.
    function automatic void model(input logic [31:0] i, input logic [2:0] s, input bit is64,
                                  output logic [63:0] v, output logic e);
        e = 1'b0;
        case (s)
            3'd0: v = {{52{i[31]}}, i[31:20]};
            3'd1: v = {{52{i[31]}}, i[31:25], i[11:7]};
            3'd2: v = {{51{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            3'd3: v = {{43{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            3'd4: v = {{32{i[31]}}, i[31:12], 12'b0};
            3'd5: begin
                if (is64) v = {58'b0, i[25:20]};
                else begin v = {59'b0, i[24:20]}; e = i[25]; end
            end
            3'd6: v = {59'b0, i[19:15]};
            default: begin v = 64'd0; e = 1'b1; end
        endcase
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        out_ready = 1'b0;
        drive(1'b1, 32'hFFF00093, 3'd0, 5'd3);
        step();
        step();
        total++; if (vld_a !== 1'b0) $display("FAIL rst_valid: got %0b want 0", vld_a); else passed++;
        total++; if (rdy_a !== 1'b1) $display("FAIL rst_ready: got %0b want 1", rdy_a); else passed++;
        total++; if (imm_a !== 32'd0 || imm_b !== 64'd0) $display("FAIL rst_imm: got %h/%h want 0", imm_a, imm_b); else passed++;
        total++; if (tag_a !== 5'd0 || err_a !== 1'b0) $display("FAIL rst_tag_err: got %0d/%0b want 0/0", tag_a, err_a); else passed++;
        reset = 1'b0;
        drive(1'b0, 32'd0, 3'd0, 5'd0);
        step();
        total++; if (vld_a !== 1'b0) $display("FAIL rst_idle_valid: got %0b want 0", vld_a); else passed++;
    endtask

    task automatic test_decode();
        logic [31:0] w   [4] = '{32'hFFF00093, 32'hFE112E23, 32'hFE000EE3, 32'h0080006F};
        logic [2:0]  s   [4] = '{3'd0, 3'd1, 3'd2, 3'd3};
        logic [31:0] e32 [4] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'h00000008};
        logic [63:0] e64 [4] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFC,
                                 64'hFFFFFFFFFFFFFFFC, 64'h0000000000000008};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, w[i], s[i], 5'(i + 1));
            step();
            total++; if (vld_a !== 1'b1 || rdy_a !== 1'b1) $display("FAIL dec%0d_hs: got v%0b r%0b want v1 r1", i, vld_a, rdy_a); else passed++;
            total++; if (imm_a !== e32[i]) $display("FAIL dec%0d_imm32: got %h want %h", i, imm_a, e32[i]); else passed++;
            total++; if (imm_b !== e64[i]) $display("FAIL dec%0d_imm64: got %h want %h", i, imm_b, e64[i]); else passed++;
            total++; if (tag_a !== 5'(i + 1) || err_a !== 1'b0) $display("FAIL dec%0d_tag: got %0d/%0b want %0d/0", i, tag_a, err_a, i + 1); else passed++;
        end
        drive(1'b0, 32'd0, 3'd0, 5'd0);
        step();
        total++; if (vld_a !== 1'b0) $display("FAIL dec_drain: got %0b want 0", vld_a); else passed++;
    endtask

    task automatic test_u_width();
        out_ready = 1'b1;
        drive(1'b1, 32'h800000B7, 3'd4, 5'd7);
        step();
        total++; if (imm_a !== 32'h80000000) $display("FAIL u_imm32: got %h want 80000000", imm_a); else passed++;
        total++; if (imm_b !== 64'hFFFFFFFF80000000) $display("FAIL u_imm64: got %h want ffffffff80000000", imm_b); else passed++;
        drive(1'b0, 32'd0, 3'd0, 5'd0);
        step();
    endtask

    task automatic test_shamt_zimm_illegal();
        out_ready = 1'b1;
        drive(1'b1, 32'h02300013, 3'd5, 5'd10);
        step();
        total++; if (imm_a !== 32'd3 || err_a !== 1'b1) $display("FAIL shamt32: got %0d/%0b want 3/1", imm_a, err_a); else passed++;
        total++; if (imm_b !== 64'd35 || err_b !== 1'b0) $display("FAIL shamt64: got %0d/%0b want 35/0", imm_b, err_b); else passed++;
        drive(1'b1, 32'h000F8073, 3'd6, 5'd11);
        step();
        total++; if (imm_a !== 32'h1F || err_a !== 1'b0 || imm_b !== 64'h1F) $display("FAIL zimm: got %h/%0b/%h want 1f/0/1f", imm_a, err_a, imm_b); else passed++;
        drive(1'b1, 32'hFFFFFFFF, 3'd7, 5'd12);
        step();
        total++; if (imm_a !== 32'd0 || err_a !== 1'b1) $display("FAIL illegal32: got %h/%0b want 0/1", imm_a, err_a); else passed++;
        total++; if (imm_b !== 64'd0 || err_b !== 1'b1 || tag_b !== 5'd12) $display("FAIL illegal64: got %h/%0b/%0d want 0/1/12", imm_b, err_b, tag_b); else passed++;
        drive(1'b0, 32'd0, 3'd0, 5'd0);
        step();
    endtask

    task automatic test_backpressure();
        // I-type immediate equals the tag so both fields identify the entry.
        out_ready = 1'b0;
        drive(1'b1, 32'h00100013, 3'd0, 5'd1);
        step();
        total++; if (vld_a !== 1'b1 || rdy_a !== 1'b1 || tag_a !== 5'd1) $display("FAIL bp_first: got v%0b r%0b t%0d want v1 r1 t1", vld_a, rdy_a, tag_a); else passed++;
        drive(1'b1, 32'h00200013, 3'd0, 5'd2);
        step();
        total++; if (rdy_a !== 1'b0) $display("FAIL bp_full_ready: got %0b want 0", rdy_a); else passed++;
        total++; if (tag_a !== 5'd1 || imm_a !== 32'd1) $display("FAIL bp_hold1: got t%0d i%h want t1 i1", tag_a, imm_a); else passed++;
        drive(1'b1, 32'h00300013, 3'd0, 5'd3);
        step();
        total++; if (rdy_a !== 1'b0 || vld_a !== 1'b1 || tag_a !== 5'd1 || imm_a !== 32'd1) $display("FAIL bp_hold2: got r%0b v%0b t%0d i%h want r0 v1 t1 i1", rdy_a, vld_a, tag_a, imm_a); else passed++;
        out_ready = 1'b1;
        step();
        total++; if (tag_a !== 5'd2 || imm_a !== 32'd2 || rdy_a !== 1'b1) $display("FAIL bp_out2: got t%0d i%h r%0b want t2 i2 r1", tag_a, imm_a, rdy_a); else passed++;
        step();
        total++; if (tag_a !== 5'd3 || imm_a !== 32'd3 || vld_a !== 1'b1) $display("FAIL bp_out3: got t%0d i%h v%0b want t3 i3 v1", tag_a, imm_a, vld_a); else passed++;
        drive(1'b0, 32'd0, 3'd0, 5'd0);
        step();
        total++; if (vld_a !== 1'b0) $display("FAIL bp_nodup: got %0b want 0", vld_a); else passed++;
    endtask

    task automatic test_reset_full();
        out_ready = 1'b0;
        drive(1'b1, 32'h00400013, 3'd0, 5'd4);
        step();
        drive(1'b1, 32'h00500013, 3'd0, 5'd5);
        step();
        total++; if (rdy_a !== 1'b0) $display("FAIL rf_full: got %0b want 0", rdy_a); else passed++;
        reset = 1'b1;
        drive(1'b1, 32'h00600013, 3'd0, 5'd6);
        step();
        total++; if (vld_a !== 1'b0 || rdy_a !== 1'b1) $display("FAIL rf_hs: got v%0b r%0b want v0 r1", vld_a, rdy_a); else passed++;
        total++; if (imm_a !== 32'd0 || tag_a !== 5'd0 || err_a !== 1'b0) $display("FAIL rf_zero: got %h/%0d/%0b want 0/0/0", imm_a, tag_a, err_a); else passed++;
        reset = 1'b0;
        out_ready = 1'b1;
        drive(1'b1, 32'h00900013, 3'd0, 5'd9);
        step();
        total++; if (vld_a !== 1'b1 || tag_a !== 5'd9 || imm_a !== 32'd9) $display("FAIL rf_next: got v%0b t%0d i%h want v1 t9 i9", vld_a, tag_a, imm_a); else passed++;
        drive(1'b0, 32'd0, 3'd0, 5'd0);
        step();
        total++; if (vld_a !== 1'b0) $display("FAIL rf_dropped: got %0b want 0", vld_a); else passed++;
    endtask

    task automatic test_random();
        int          sent = 0;
        int          cyc  = 0;
        bit          acc, drn, stalled;
        logic [107:0] held;
        exp_t        e;
        logic [63:0] v;
        logic        er;
        stalled = 1'b0;
        held = '0;
        drive(1'b0, 32'd0, 3'd0, 5'd0);
        out_ready = 1'b1;
        while (cyc < 80000) begin
            @(negedge clk);
            cyc++;
            if (stalled) begin
                total++;
                if ({imm_a, tag_a, err_a, imm_b, tag_b, err_b} !== held)
                    $display("FAIL rnd_stable cyc%0d: got %h want %h", cyc, {imm_a, tag_a, err_a, imm_b, tag_b, err_b}, held);
                else passed++;
            end
            acc = in_valid && rdy_a;
            drn = vld_a && out_ready;
            if (drn) begin
                total++;
                if (q.size() == 0) begin
                    $display("FAIL rnd_extra cyc%0d: got output t%0d want none", cyc, tag_a);
                end else begin
                    e = q.pop_front();
                    if (imm_a !== e.a || tag_a !== e.t || err_a !== e.ea || imm_b !== e.b || tag_b !== e.t || err_b !== e.eb)
                        $display("FAIL rnd_data cyc%0d: got %h/%0d/%0b %h/%0b want %h/%0d/%0b %h/%0b",
                                 cyc, imm_a, tag_a, err_a, imm_b, err_b, e.a, e.t, e.ea, e.b, e.eb);
                    else passed++;
                end
            end
            if (acc) begin
                model(instr, sel, 1'b0, v, er);
                e.a = v[31:0];
                e.ea = er;
                model(instr, sel, 1'b1, v, er);
                e.b = v;
                e.eb = er;
                e.t = tag;
                q.push_back(e);
                sent++;
            end
            stalled = vld_a && !out_ready;
            held = {imm_a, tag_a, err_a, imm_b, tag_b, err_b};
            if (sent >= 10000 && q.size() == 0 && !vld_a) break;
            @(posedge clk);
            #1;
            if (sent >= 10000) begin
                in_valid  = 1'b0;
                out_ready = 1'b1;
            end else begin
                if (acc || !in_valid) begin
                    in_valid = ($urandom_range(0, 9) < 7);
                    instr    = $urandom;
                    sel      = 3'($urandom_range(0, 7));
                    tag      = 5'($urandom);
                end
                out_ready = ($urandom_range(0, 9) < 7);
            end
        end
        total++;
        if (sent < 10000 || q.size() != 0)
            $display("FAIL rnd_timeout: got sent %0d pending %0d want 10000/0", sent, q.size());
        else passed++;
    endtask

    initial begin
        drive(1'b0, 32'd0, 3'd0, 5'd0);
        reset = 1'b1;
        out_ready = 1'b0;
        test_reset();
        test_decode();
        test_u_width();
        test_shamt_zimm_illegal();
        test_backpressure();
        test_reset_full();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/imm_extend_pipe.md
# imm_extend_pipe

Parametrised, pipelined immediate generator for the decode stage. It accepts an instruction word and an immediate-source select over a valid/ready handshake. It produces the sign- or zero-extended immediate at XLEN bits, registered, with a two-entry skid buffer so downstream backpressure never drops or duplicates an immediate. It adds RV64 support and shift-amount / CSR-zimm formats, with an error flag for unsupported selects, and carries a tag alongside each immediate.

## Interface
- XLEN, 32, datapath width; legal values 32 or 64 only.
- TAG_W, 5, width of the sideband tag (typically rd index) passed through with each immediate.
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset; sampled on rising edge of clk.
- in_valid  in  1  upstream presents instr/immsrc/tag.
- in_ready  out  1  block can accept; transfer when in_valid && in_ready.
- in_instr  in  [31:7]  instruction bits 31..7.
- in_immsrc  in  3  format select (encodings below).
- in_tag  in  TAG_W  sideband, returned unchanged with result.
- out_valid  out  1  out_immext/out_tag/out_err valid.
- out_ready  in  1  downstream accepts; transfer when out_valid && out_ready.
- out_immext  out  XLEN  extended immediate.
- out_tag  out  TAG_W  tag of the presented result.
- out_err  out  1  immsrc was unsupported for this XLEN.

## Operation
- Formats; S = sign extension of instr[31] to XLEN:
  - 000 I: S, instr[31:20].
  - 001 S: S, instr[31:25], instr[11:7].
  - 010 B: S, instr[7], instr[30:25], instr[11:8], 0.
  - 011 J: S, instr[19:12], instr[20], instr[30:21], 0.
  - 100 U: S from bit 31, instr[31:12], 12'b0. XLEN=64 sign-extends bit 31 into [63:32].
  - 101 SHAMT: zero-extended instr[24:20] (XLEN=32) or instr[25:20] (XLEN=64).
  - 110 ZIMM: zero-extended instr[19:15] (CSR immediate).
  - 111: illegal; out_immext = 0, out_err = 1.
- XLEN=32 with SHAMT and instr[25]=1: out_err = 1, immext still = zero-extended instr[24:20].
- out_err = 0 for every other case.
- Storage: output register (OUT) plus skid register (SKID), each holding {immext, tag, err} and a valid bit.
- States: EMPTY (OUT and SKID invalid), ONE (OUT valid, SKID invalid), FULL (both valid).
- in_ready = !SKID.valid, which is registered; no combinational path from out_ready to in_ready.
- Transitions:
  - EMPTY + accept -> ONE; decoded value loads OUT.
  - ONE + accept + drain -> ONE; OUT reloads with the new value.
  - ONE + accept + no drain -> FULL; the new value goes to SKID.
  - ONE + drain only -> EMPTY.
  - FULL + drain -> ONE; SKID moves to OUT. No accept is possible in FULL.
  - No event -> state held.
- Ordering strictly FIFO; every accepted input produces exactly one output transfer.
- out_immext/out_tag/out_err remain stable while out_valid && !out_ready.
- Decode is combinational from the in_* inputs into the load path only; outputs are driven purely from OUT.

## Timing
- Latency: input accepted at edge N -> out_valid high after edge N, visible in cycle N+1.
- Throughput: one immediate per cycle while out_ready stays high.
- Reset (any state, including FULL): after the reset edge, out_valid=0, in_ready=1, out_immext=0, out_tag=0, out_err=0, SKID.valid=0.
  - Inputs presented in a reset cycle are discarded.
  - Pending results are dropped.
- Simultaneous accept and drain in ONE: the drained value is the old OUT; the new value appears the next cycle.
- in_valid with in_ready low: no state change; upstream must hold its inputs.

## Test plan
- I/B/J decode, XLEN=32, out_ready=1:
  - 0xFFF00093 sel 000 -> 0xFFFFFFFF.
  - 0xFE000EE3 sel 010 -> 0xFFFFFFFC.
  - 0x0080006F sel 011 -> 0x00000008.
  - Each result appears one cycle after accept, back-to-back, tags preserved.
- U-type width rule: 0x800000B7 sel 100 -> 0x80000000 at XLEN=32; 0xFFFFFFFF80000000 at XLEN=64.
- SHAMT/ZIMM/illegal:
  - instr[25:20]=6'b100011 sel 101: XLEN=64 -> 35, err=0; XLEN=32 -> 3, err=1.
  - instr[19:15]=5'h1F sel 110 -> 0x1F.
  - sel 111 -> immext 0, err=1.
- Backpressure:
  - Hold out_ready=0 and push three inputs (tags 1,2,3): first two accepted, in_ready drops after the second, outputs stable.
  - Release out_ready: outputs tags 1,2,3 in order with no loss or duplication.
- Reset in FULL: fill both entries, assert reset one cycle -> out_valid=0, in_ready=1, outputs zero; the next input emerges with latency 1.
- Random stress: random in_valid/out_ready over 10k transactions vs. a reference model queue; zero mismatches, stability held under stall.
